gp_fifo_param: RTL and testbench
================================

Name: gp_fifo_param

Overview:
Parametrised synchronous FIFO that succeeds the fixed 32x34 general-purpose interconnect FIFO. It is used for the read/write buffers between NoC router ports and the neuron-core network interface.
- Configurable data width, depth and almost-full/almost-empty thresholds.
- Full-width occupancy count.
- Sticky overflow/underflow status.
- Read and write may complete in the same cycle while full.
- Single clock domain.

Parameters:
DATA_W, 34, data word width in bits (>=1)
DEPTH, 32, number of slots; power of two, >=2
AF_LEVEL, 28, almost_full asserts when ocup >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserts when ocup <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
write_en  in  1  write request
data_in  in  DATA_W  write data
read_en  in  1  read request (pops head)
data_out  out  DATA_W  head-of-FIFO data
full  out  1  ocup == DEPTH
empty  out  1  ocup == 0
almost_full  out  1  ocup >= AF_LEVEL
almost_empty  out  1  ocup <= AE_LEVEL
ocup  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
error  out  1  combinational: rejected write or rejected read this cycle
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected
err_clr  in  1  clears overflow/underflow

Behaviour:
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. The slot index is the low $clog2(DEPTH) bits. ocup = wr_ptr - rd_ptr, truncated to the pointer width (no modulo loss at DEPTH).
- Reset (reset_n=0 at a clock edge) has these required effects:
  - wr_ptr=rd_ptr=0, overflow=underflow=0.
  - Outputs read empty=1, full=0, ocup=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0); AF_LEVEL>=1 makes this 0.
  - data_out=0, error=0.
  - Storage array is NOT reset.
  - Reset mid-operation discards all contents. Requests in the reset cycle are ignored.
- Read accept: rd_acc = read_en && !empty.
- Write accept: wr_acc = write_en && (!full || rd_acc). Writing while full is allowed only if a read is accepted in the same cycle.
- On accepted write, data_in is stored at wr_ptr and wr_ptr increments at the clock edge. On accepted read, rd_ptr increments.
- Both accepted: ocup unchanged, both pointers advance.
- Empty with read_en && write_en: the write is accepted, the read is rejected (error=1, underflow sets). Data does not bypass.
- data_out is show-ahead: mem[rd_ptr] when !empty, else 0. No read latency. A popped word is visible in the same cycle read_en is asserted.
- error = (write_en && !wr_acc) || (read_en && !rd_acc). Rejected requests leave pointers and contents unchanged.
- overflow/underflow set on the edge after a rejected write/read.
  - err_clr=1 clears both.
  - If err_clr and a new rejection occur in the same cycle, set wins.
- Flags are derived combinationally from registered pointers, so they update the cycle after the accepting edge.
- Pointer wrap is natural binary rollover, with no special casing.

Optional Feature:
Macro: GP_FIFO_OUT_REG_EN
- Defined: data_out comes from an output register, loaded on the edge of an accepted read with the popped word. Read latency is 1 cycle. An added output rd_valid (1 bit) pulses high for exactly one cycle after each accepted read.
  - data_out holds its value otherwise.
  - Reset clears data_out and rd_valid.
  - Flags and ocup are unchanged in meaning.
- Undefined: show-ahead behaviour above, and there is no rd_valid port.

Decomposition:
- gp_fifo_pkg (header/package) holds:
  - Default width/depth constants: GP_FIFO_DATA_W=34, GP_FIFO_DEPTH=32.
  - Pointer-width function clog2.
  - Packet field constants shared with the network interface.
- Sub-module gp_fifo_ram holds the DEPTH x DATA_W storage array.
  - Write port: we, waddr, wdata. Async read port: raddr, rdata.
  - It is not reset, so it can map to distributed RAM.
- Top level holds pointers, flags, status and the optional output register.

Test Plan:
- Reset then idle (DEPTH=32) -> empty=1, full=0, ocup=0, almost_empty=1, data_out=0, error=0.
- Write 32 words 0x1..0x20 -> ocup counts to 32 (6-bit, not 0); almost_full at ocup=28; full=1. A 33rd write gives error=1, overflow=1 and ocup stays 32.
- Full, then read_en+write_en with data 0x3FF -> both accepted, ocup=32, error=0. data_out sequence 0x2..0x20 then 0x3FF.
- Empty with read_en only -> error=1, underflow=1. Then err_clr=1 -> underflow=0. Empty with read+write simultaneously -> ocup=1, underflow set.
- Wrap-around: 100 cycles of single write/read interleave with depth 4 (DEPTH=4, AF=3, AE=1) -> data in order, thresholds correct, no error.
- Reset_n low with ocup=17 mid-stream -> next cycle ocup=0, empty=1. With GP_FIFO_OUT_REG_EN: read of 0xABC gives data_out=0xABC and rd_valid=1 exactly one cycle after acceptance.

Source files
------------

// File: rtl/gp_fifo_pkg.sv
// Shared constants for the general-purpose interconnect FIFO and the network-interface word layout.
// Holds the default geometry, the pointer-width helper and packet field accessors.
package gp_fifo_pkg;

    localparam int GP_FIFO_DATA_W = 34;
    localparam int GP_FIFO_DEPTH  = 32;

    // Word layout used by the neuron-core network interface
    localparam int GP_PKT_PAYLOAD_LSB = 0;
    localparam int GP_PKT_PAYLOAD_W   = 24;
    localparam int GP_PKT_DEST_LSB    = 24;
    localparam int GP_PKT_DEST_W      = 8;
    localparam int GP_PKT_TYPE_LSB    = 32;
    localparam int GP_PKT_TYPE_W      = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [GP_PKT_PAYLOAD_W-1:0] pkt_payload(input logic [GP_FIFO_DATA_W-1:0] w);
        return w[GP_PKT_PAYLOAD_LSB +: GP_PKT_PAYLOAD_W];
    endfunction

    function automatic logic [GP_PKT_DEST_W-1:0] pkt_dest(input logic [GP_FIFO_DATA_W-1:0] w);
        return w[GP_PKT_DEST_LSB +: GP_PKT_DEST_W];
    endfunction

    function automatic logic [GP_PKT_TYPE_W-1:0] pkt_type(input logic [GP_FIFO_DATA_W-1:0] w);
        return w[GP_PKT_TYPE_LSB +: GP_PKT_TYPE_W];
    endfunction

endpackage

// File: rtl/gp_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, 0-cycle read latency.
// No reset and no flow control, so the array can map onto distributed RAM.
module gp_fifo_ram
    import gp_fifo_pkg::*;
#(
    parameter int DATA_W = GP_FIFO_DATA_W,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/gp_fifo_param.sv
// Parametrised synchronous FIFO with occupancy, threshold flags and sticky overflow/underflow status.
// Show-ahead read (0 cycles); with GP_FIFO_OUT_REG_EN the popped word is registered (1 cycle, rd_valid).
// Writes into a full FIFO succeed only alongside an accepted read; rejected requests raise error.
module gp_fifo_param
    import gp_fifo_pkg::*;
#(
    parameter int DATA_W   = GP_FIFO_DATA_W,
    parameter int DEPTH    = GP_FIFO_DEPTH,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    write_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    read_en,
    output logic [DATA_W-1:0]       data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   ocup,
    output logic                    error,
    output logic                    overflow,
    output logic                    underflow,
`ifdef GP_FIFO_OUT_REG_EN
    output logic                    rd_valid,
`endif
    input  logic                    err_clr
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LP_DEPTH = PW'(DEPTH);
    localparam logic [PW-1:0] LP_AF    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] LP_AE    = PW'(AE_LEVEL);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     w_ocup;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_wr_rej;
    logic              w_rd_rej;
    logic [DATA_W-1:0] w_rdata;
    logic              r_overflow;
    logic              r_underflow;

    // The extra wrap bit keeps DEPTH distinct from 0 in the pointer difference
    assign w_ocup   = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_ocup == '0);
    assign w_full   = (w_ocup == LP_DEPTH);
    assign w_rd_acc = read_en && !w_empty;
    assign w_wr_acc = write_en && (!w_full || w_rd_acc);
    assign w_wr_rej = write_en && !w_wr_acc;
    assign w_rd_rej = read_en && !w_rd_acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // A new rejection outranks a clear arriving in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_rej)     r_overflow <= 1'b1;
            else if (err_clr) r_overflow <= 1'b0;
            if (w_rd_rej)     r_underflow <= 1'b1;
            else if (err_clr) r_underflow <= 1'b0;
        end
    end

    gp_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_acc && reset_n),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_rdata)
    );

`ifdef GP_FIFO_OUT_REG_EN
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_data_out <= w_rdata;
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
`else
    assign data_out = w_empty ? '0 : w_rdata;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_ocup >= LP_AF);
    assign almost_empty = (w_ocup <= LP_AE);
    assign ocup         = w_ocup;
    assign error        = reset_n && (w_wr_rej || w_rd_rej);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_gp_fifo_param.sv
// Bench for gp_fifo_param: a 32-deep and a 4-deep instance checked every cycle against queue models.
module tb_gp_fifo_param;

    localparam int DW = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          a_we, a_re, a_clr;
    logic [DW-1:0] a_din, a_dout;
    logic          a_full, a_empty, a_af, a_ae, a_err, a_ovf, a_unf;
    logic [5:0]    a_ocup;

    logic          b_we, b_re, b_clr;
    logic [DW-1:0] b_din, b_dout;
    logic          b_full, b_empty, b_af, b_ae, b_err, b_ovf, b_unf;
    logic [2:0]    b_ocup;

`ifdef GP_FIFO_OUT_REG_EN
    logic          a_rv, b_rv;
    logic [DW-1:0] ea_dout, eb_dout;
`endif

    wire [6:0] a_stat = {a_empty, a_full, a_af, a_ae, a_err, a_ovf, a_unf};
    wire [6:0] b_stat = {b_empty, b_full, b_af, b_ae, b_err, b_ovf, b_unf};

    gp_fifo_param u_dut_a (
        .clk          (clk),
        .reset_n      (rst_n),
        .write_en     (a_we),
        .data_in      (a_din),
        .read_en      (a_re),
        .data_out     (a_dout),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_af),
        .almost_empty (a_ae),
        .ocup         (a_ocup),
        .error        (a_err),
        .overflow     (a_ovf),
        .underflow    (a_unf),
`ifdef GP_FIFO_OUT_REG_EN
        .rd_valid     (a_rv),
`endif
        .err_clr      (a_clr)
    );

    gp_fifo_param #(
        .DATA_W   (DW),
        .DEPTH    (4),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) u_dut_b (
        .clk          (clk),
        .reset_n      (rst_n),
        .write_en     (b_we),
        .data_in      (b_din),
        .read_en      (b_re),
        .data_out     (b_dout),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_af),
        .almost_empty (b_ae),
        .ocup         (b_ocup),
        .error        (b_err),
        .overflow     (b_ovf),
        .underflow    (b_unf),
`ifdef GP_FIFO_OUT_REG_EN
        .rd_valid     (b_rv),
`endif
        .err_clr      (b_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic ea_ovf, ea_unf, eb_ovf, eb_unf;

    function automatic logic acc_rd(input int n, input logic re);
        return re && (n > 0);
    endfunction

    function automatic logic acc_wr(input int n, input int depth, input logic we, input logic re);
        return we && ((n < depth) || acc_rd(n, re));
    endfunction

    function automatic logic [6:0] stat_a();
        int   n  = qa.size();
        logic ra = acc_rd(n, a_re);
        logic wa = acc_wr(n, 32, a_we, a_re);
        return {n == 0, n == 32, n >= 28, n <= 4, (a_we && !wa) || (a_re && !ra), ea_ovf, ea_unf};
    endfunction

    function automatic logic [6:0] stat_b();
        int   n  = qb.size();
        logic rb = acc_rd(n, b_re);
        logic wb = acc_wr(n, 4, b_we, b_re);
        return {n == 0, n == 4, n >= 3, n <= 1, (b_we && !wb) || (b_re && !rb), eb_ovf, eb_unf};
    endfunction

    function automatic logic [DW-1:0] dout_a();
`ifdef GP_FIFO_OUT_REG_EN
        return ea_dout;
`else
        return (qa.size() > 0) ? qa[0] : '0;
`endif
    endfunction

    function automatic logic [DW-1:0] dout_b();
`ifdef GP_FIFO_OUT_REG_EN
        return eb_dout;
`else
        return (qb.size() > 0) ? qb[0] : '0;
`endif
    endfunction

    task automatic drive_a(input logic we, input logic [DW-1:0] din, input logic re, input logic clr);
        a_we = we; a_din = din; a_re = re; a_clr = clr;
    endtask

    task automatic drive_b(input logic we, input logic [DW-1:0] din, input logic re, input logic clr);
        b_we = we; b_din = din; b_re = re; b_clr = clr;
    endtask

    // Advance one clock: decide acceptance from the model before the edge, update after it
    task automatic tick();
        logic ra, wa, rb, wb;
        ra = acc_rd(qa.size(), a_re);
        wa = acc_wr(qa.size(), 32, a_we, a_re);
        rb = acc_rd(qb.size(), b_re);
        wb = acc_wr(qb.size(), 4, b_we, b_re);
        @(posedge clk);
        if (!rst_n) begin
            qa.delete(); qb.delete();
            ea_ovf = 1'b0; ea_unf = 1'b0; eb_ovf = 1'b0; eb_unf = 1'b0;
`ifdef GP_FIFO_OUT_REG_EN
            ea_dout = '0; eb_dout = '0;
`endif
        end else begin
`ifdef GP_FIFO_OUT_REG_EN
            if (ra) ea_dout = qa[0];
            if (rb) eb_dout = qb[0];
`endif
            if (ra) void'(qa.pop_front());
            if (wa) qa.push_back(a_din);
            if (rb) void'(qb.pop_front());
            if (wb) qb.push_back(b_din);
            if (a_we && !wa) ea_ovf = 1'b1; else if (a_clr) ea_ovf = 1'b0;
            if (a_re && !ra) ea_unf = 1'b1; else if (a_clr) ea_unf = 1'b0;
            if (b_we && !wb) eb_ovf = 1'b1; else if (b_clr) eb_ovf = 1'b0;
            if (b_re && !rb) eb_unf = 1'b1; else if (b_clr) eb_unf = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(1'b1, 'h55, 1'b1, 1'b0);
        drive_b(1'b1, 'h66, 1'b1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        drive_a(1'b0, '0, 1'b0, 1'b0);
        drive_b(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if (a_stat !== 7'b1001000) begin n_fail++; $display("FAIL reset_stat_a got=%b exp=%b", a_stat, 7'b1001000); end
        n_checks++; if (a_ocup !== 6'd0) begin n_fail++; $display("FAIL reset_ocup_a got=%0d exp=0", a_ocup); end
        n_checks++; if (a_dout !== '0) begin n_fail++; $display("FAIL reset_dout_a got=%h exp=0", a_dout); end
        n_checks++; if (b_stat !== 7'b1001000) begin n_fail++; $display("FAIL reset_stat_b got=%b exp=%b", b_stat, 7'b1001000); end
        n_checks++; if (b_ocup !== 3'd0) begin n_fail++; $display("FAIL reset_ocup_b got=%0d exp=0", b_ocup); end
`ifdef GP_FIFO_OUT_REG_EN
        n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL reset_rv_a got=%b exp=0", a_rv); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 32; i++) begin
            drive_a(1'b1, DW'(i), 1'b0, 1'b0);
            #1;
            n_checks++; if (a_stat !== stat_a()) begin n_fail++; $display("FAIL fill_stat got=%b exp=%b", a_stat, stat_a()); end
            n_checks++; if (a_ocup !== 6'(qa.size())) begin n_fail++; $display("FAIL fill_ocup got=%0d exp=%0d", a_ocup, qa.size()); end
            n_checks++; if (a_dout !== dout_a()) begin n_fail++; $display("FAIL fill_dout got=%h exp=%h", a_dout, dout_a()); end
            tick();
        end
        drive_a(1'b1, 'h21, 1'b0, 1'b0);
        #1;
        n_checks++; if (a_ocup !== 6'd32) begin n_fail++; $display("FAIL full_ocup got=%0d exp=32", a_ocup); end
        n_checks++; if ({a_full, a_af, a_err} !== 3'b111) begin n_fail++; $display("FAIL full_flags got=%b exp=111", {a_full, a_af, a_err}); end
        tick();
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if ({a_ovf, a_ocup} !== {1'b1, 6'd32}) begin n_fail++; $display("FAIL overflow_hold got=%b/%0d exp=1/32", a_ovf, a_ocup); end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] got, want;
        drive_a(1'b1, 'h3FF, 1'b1, 1'b0);
        #1;
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL full_rw_err got=%b exp=0", a_err); end
        tick();
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if (a_ocup !== 6'd32) begin n_fail++; $display("FAIL full_rw_ocup got=%0d exp=32", a_ocup); end
        for (int k = 0; k < 32; k++) begin
            want = (k < 31) ? DW'(k + 2) : DW'('h3FF);
            drive_a(1'b0, '0, 1'b1, 1'b0);
            #1;
            got = a_dout;
            n_checks++; if (a_stat !== stat_a()) begin n_fail++; $display("FAIL drain_stat got=%b exp=%b", a_stat, stat_a()); end
            n_checks++; if (a_ocup !== 6'(qa.size())) begin n_fail++; $display("FAIL drain_ocup got=%0d exp=%0d", a_ocup, qa.size()); end
            tick();
`ifdef GP_FIFO_OUT_REG_EN
            got = a_dout;
`endif
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL drain_seq[%0d] got=%h exp=%h", k, got, want); end
        end
        drive_a(1'b0, '0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_underflow();
        drive_a(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL unf_err got=%b exp=1", a_err); end
        tick();
        drive_a(1'b0, '0, 1'b0, 1'b1);
        #1;
        n_checks++; if (a_unf !== 1'b1) begin n_fail++; $display("FAIL unf_set got=%b exp=1", a_unf); end
        tick();
        drive_a(1'b1, 'h123, 1'b1, 1'b0);
        #1;
        n_checks++; if ({a_unf, a_ovf, a_err} !== 3'b001) begin n_fail++; $display("FAIL unf_clr_rw got=%b exp=001", {a_unf, a_ovf, a_err}); end
        tick();
        drive_a(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if ({a_ocup, a_unf} !== {6'd1, 1'b1}) begin n_fail++; $display("FAIL rw_empty got=%0d/%b exp=1/1", a_ocup, a_unf); end
`ifndef GP_FIFO_OUT_REG_EN
        n_checks++; if (a_dout !== DW'('h123)) begin n_fail++; $display("FAIL rw_empty_dout got=%h exp=123", a_dout); end
`endif
        tick();
        drive_a(1'b0, '0, 1'b0, 1'b1);
        tick();
        drive_a(1'b0, '0, 1'b1, 1'b1);
        tick();
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if (a_unf !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%b exp=1", a_unf); end
        n_checks++; if (a_stat !== stat_a()) begin n_fail++; $display("FAIL set_wins_stat got=%b exp=%b", a_stat, stat_a()); end
        drive_a(1'b0, '0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 100; i++) begin
            drive_b(i % 2 == 0, DW'({$urandom(), $urandom()}), i % 2 == 1, 1'b0);
            #1;
            n_checks++; if (b_stat !== stat_b()) begin n_fail++; $display("FAIL wrap_stat got=%b exp=%b", b_stat, stat_b()); end
            n_checks++; if (b_dout !== dout_b()) begin n_fail++; $display("FAIL wrap_dout got=%h exp=%h", b_dout, dout_b()); end
            n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err got=%b exp=0", b_err); end
            tick();
        end
        drive_b(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_a($urandom_range(99, 0) < 55, DW'({$urandom(), $urandom()}), $urandom_range(99, 0) < 45,
                    $urandom_range(99, 0) < 5);
            drive_b($urandom_range(99, 0) < 50, DW'({$urandom(), $urandom()}), $urandom_range(99, 0) < 50,
                    $urandom_range(99, 0) < 8);
            #1;
            n_checks++; if (a_stat !== stat_a()) begin n_fail++; $display("FAIL rnd_stat_a got=%b exp=%b", a_stat, stat_a()); end
            n_checks++; if (a_ocup !== 6'(qa.size())) begin n_fail++; $display("FAIL rnd_ocup_a got=%0d exp=%0d", a_ocup, qa.size()); end
            n_checks++; if (a_dout !== dout_a()) begin n_fail++; $display("FAIL rnd_dout_a got=%h exp=%h", a_dout, dout_a()); end
            n_checks++; if (b_stat !== stat_b()) begin n_fail++; $display("FAIL rnd_stat_b got=%b exp=%b", b_stat, stat_b()); end
            n_checks++; if (b_ocup !== 3'(qb.size())) begin n_fail++; $display("FAIL rnd_ocup_b got=%0d exp=%0d", b_ocup, qb.size()); end
            n_checks++; if (b_dout !== dout_b()) begin n_fail++; $display("FAIL rnd_dout_b got=%h exp=%h", b_dout, dout_b()); end
            tick();
        end
        drive_a(1'b0, '0, 1'b0, 1'b0);
        drive_b(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_a(1'b1, DW'({$urandom(), $urandom()}), 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if (a_ocup !== 6'd17) begin n_fail++; $display("FAIL mid_ocup got=%0d exp=17", a_ocup); end
        rst_n = 1'b0;
        drive_a(1'b1, 'h77, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if ({a_ocup, a_empty} !== {6'd0, 1'b1}) begin n_fail++; $display("FAIL mid_reset got=%0d/%b exp=0/1", a_ocup, a_empty); end
        n_checks++; if (a_dout !== '0) begin n_fail++; $display("FAIL mid_reset_dout got=%h exp=0", a_dout); end
    endtask

`ifdef GP_FIFO_OUT_REG_EN
    task automatic test_outreg();
        drive_a(1'b1, 'hABC, 1'b0, 1'b0);
        tick();
        drive_a(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL outreg_rv_pre got=%b exp=0", a_rv); end
        tick();
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if ({a_rv, a_dout} !== {1'b1, DW'('hABC)}) begin n_fail++; $display("FAIL outreg_pop got=%b/%h exp=1/abc", a_rv, a_dout); end
        tick();
        n_checks++; if ({a_rv, a_dout} !== {1'b0, DW'('hABC)}) begin n_fail++; $display("FAIL outreg_hold got=%b/%h exp=0/abc", a_rv, a_dout); end
        n_checks++; if (b_rv !== 1'b0) begin n_fail++; $display("FAIL outreg_rv_b got=%b exp=0", b_rv); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ea_ovf = 1'b0; ea_unf = 1'b0; eb_ovf = 1'b0; eb_unf = 1'b0;
`ifdef GP_FIFO_OUT_REG_EN
        ea_dout = '0; eb_dout = '0;
`endif
        drive_a(1'b0, '0, 1'b0, 1'b0);
        drive_b(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_full_rw();
        test_underflow();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef GP_FIFO_OUT_REG_EN
        test_outreg();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
